// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The slave modport is the loader; the master modport is the stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 28
);
    // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
    // the source holds byte_data steady while byte_valid is high and unaccepted.
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a big-endian word-count header, assembles
// big-endian words and writes them at 0,4,8,...; holds the CPU until the image is complete.
module imem_loader #(
    parameter  int ADDR_WIDTH = 28,
    parameter  int MAX_WORDS  = 1024,
    localparam int CW         = $clog2(MAX_WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] words_loaded,
    output logic [2:0]    dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_cnt;
    logic [31:0]           r_word;
    logic [1:0]            r_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         r_words;

    logic                  w_ready;
    logic                  w_fire;
    logic                  w_start_ok;
    logic [31:0]           w_hdr_n;
    logic [CW-1:0]         w_words_inc;

    assign w_ready     = (r_state == S_HDR) || (r_state == S_DATA);
    assign w_fire      = bus.byte_valid && w_ready;
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_hdr_n     = {r_cnt[23:0], bus.byte_data};
    assign w_words_inc = r_words + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_next = S_HDR;
                end
            end
            S_HDR: begin
                if (w_fire && (r_idx == 2'd3)) begin
                    if (w_hdr_n == 32'd0) begin
                        w_next = S_DONE;
                    end else if (w_hdr_n > 32'(MAX_WORDS)) begin
                        w_next = S_ERR;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_fire && (r_idx == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                // r_cnt is only ever a legal count here, so CW bits of it suffice
                if ({{(32-CW){1'b0}}, w_words_inc} == r_cnt) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_DATA;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_word  <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_words <= '0;
        end else begin
            if (w_start_ok) begin
                r_cnt   <= '0;
                r_idx   <= '0;
                r_addr  <= '0;
                r_words <= '0;
            end
            if (w_fire) begin
                r_idx <= r_idx + 2'd1;
                if (r_state == S_HDR) begin
                    r_cnt <= w_hdr_n;
                end else begin
                    r_word <= {r_word[23:0], bus.byte_data};
                end
            end
            if (r_state == S_WRITE) begin
                r_addr  <= r_addr + ADDR_WIDTH'(4);
                r_words <= w_words_inc;
            end
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.mem_we     = (r_state == S_WRITE);
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_word;
    assign cpu_hold       = (r_state != S_DONE);
    assign busy           = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_WRITE);
    assign done           = (r_state == S_DONE);
    assign error          = (r_state == S_ERR);
    assign words_loaded   = r_words;
    assign dbg_state      = r_state;
endmodule
